pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 12 +
 rtl/pc_range_chk.sv | 13 +
 rtl/pc_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encoding and PC constants for the fetch sequencer
package pc_sequencer_pkg;
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOLD = 2'd1,
    S_EXC  = 2'd2
  } seq_state_t;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO_DEF    = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI_DEF    = 32'h0000_4ffc;
endpackage

// File: rtl/pc_range_chk.sv
// pc_range_chk: flags a loaded fetch address that is misaligned or outside instruction memory
module pc_range_chk
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] LO = IMEM_LO_DEF,
  parameter logic [31:0] HI = IMEM_HI_DEF
) (
  input  logic        en,
  input  logic [31:0] addr,
  output logic        bad
);
  assign bad = en && (addr[1:0] != 2'b00 || addr < LO || addr > HI);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with held redirects and exception entry; PC_SEQ_ALIGN_CHK_EN adds the adel fetch-address check
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [31:0] IMEM_LO    = IMEM_LO_DEF,
  parameter logic [31:0] IMEM_HI    = IMEM_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cur_pc,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        int_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] npc,
  output logic        pc_we,
  output logic        flush_fd,
  output logic        pend,
  output logic [15:0] redirect_cnt
`ifdef PC_SEQ_ALIGN_CHK_EN
  ,
  output logic        adel
`endif
);
  seq_state_t state, state_nxt;
  logic [31:0] pend_pc, seq_pc;
  logic        pend_eret, take_int, capture;
  assign seq_pc   = cur_pc + 32'd4;
  // an exception is accepted once; the cycle spent in EXC ignores int_req
  assign take_int = int_req && state != S_EXC;
  // a redirect arriving under stall is parked; HOLD keeps the first one it caught
  assign capture  = !reset && !take_int && state != S_HOLD && stall && (eret || br_take);
  assign pend     = !reset && !take_int && state == S_HOLD;
  // state register
  always_ff @(posedge clk)
    state <= state_nxt;
  // next-state selection
  always_comb
    state_nxt = reset ? S_RUN :
                take_int ? S_EXC :
                capture ? S_HOLD :
                (state == S_HOLD && stall) ? S_HOLD : S_RUN;
  // fetch-side outputs, combinational so an unstalled redirect applies this cycle
  always_comb begin
    npc      = seq_pc;
    pc_we    = !stall;
    flush_fd = 1'b0;
    if (reset) begin
      npc      = RESET_PC;
      pc_we    = 1'b1;
      flush_fd = 1'b1;
    end else if (take_int) begin
      npc      = HANDLER_PC;
      pc_we    = 1'b1;
      flush_fd = 1'b1;
    end else if (stall) begin
      pc_we = 1'b0;
    end else if (eret) begin
      npc      = epc;
      flush_fd = 1'b1;
    end else if (br_take) begin
      npc = br_target;
    end else if (state == S_HOLD) begin
      npc      = pend_pc;
      flush_fd = pend_eret;
    end
  end
  // pending redirect target and type, dropped by reset or exception entry
  always_ff @(posedge clk)
    if (reset || take_int) begin
      pend_pc   <= '0;
      pend_eret <= 1'b0;
    end else if (capture) begin
      pend_pc   <= eret ? epc : br_target;
      pend_eret <= eret;
    end
  // saturating count of non-sequential PC loads
  always_ff @(posedge clk)
    if (reset)
      redirect_cnt <= '0;
    else if (pc_we && npc != seq_pc && redirect_cnt != 16'hFFFF)
      redirect_cnt <= redirect_cnt + 16'd1;
`ifdef PC_SEQ_ALIGN_CHK_EN
  pc_range_chk #(.LO(IMEM_LO), .HI(IMEM_HI)) u_range_chk (
    .en  (pc_we),
    .addr(npc),
    .bad (adel)
  );
`else
  logic unused_range;
  assign unused_range = ^{IMEM_LO, IMEM_HI};
`endif
endmodule
